// File: rtl/mips_fetch_ir.sv
// Multicycle MIPS fetch stage: owns the PC, runs a req/ack read to instruction memory
// and holds the fetched word in the IR. Optional ack timeout under `FETCH_TIMEOUT_EN`.
module mips_fetch_ir #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_load,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      StIdle, StHold: begin
        // A load on the same edge as fetch_start means the request uses the loaded PC.
        if (pc_load) begin
          pc_d = {pc_next[31:2], 2'b00};
        end
        if (fetch_start) begin
          state_d    = StReq;
          ir_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      StReq: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          pc_d       = pc_q + 32'd4;
          ir_valid_d = 1'b1;
          state_d    = StHold;
        end else begin
`ifdef FETCH_TIMEOUT_EN
          if (cnt_q == CntLast) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      ir_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;
  assign instr     = ir_q;
  assign op        = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign ir_valid  = ir_valid_q;
  assign pc        = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch_ir.sv
// Directed bench for mips_fetch_ir: fixed-cycle stimulus with hand-computed expectations.
module tb_mips_fetch_ir;

  logic        clk;
  logic        reset;
  logic        fetch_start;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        ir_valid;
  logic [31:0] pc;
  logic        fetch_err;

  int n_checks;
  int n_bad;

  mips_fetch_ir #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_start(fetch_start),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .op         (op),
    .funct      (funct),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_bad       = 0;
    reset       = 1'b0;
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    pc_next     = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    #2;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_op", 32'(op), 32'h0);
    check_eq("rst_funct", 32'(funct), 32'h0);
    check_eq("rst_req", 32'(imem_req), 32'h0);
    check_eq("rst_valid", 32'(ir_valid), 32'h0);
    check_eq("rst_err", 32'(fetch_err), 32'h0);
    step();
    reset = 1'b1;
    step();

    // Single-cycle memory fetch
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("f1_req", 32'(imem_req), 32'h1);
    check_eq("f1_addr", imem_addr, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h2002_0005;
    step();
    imem_ack = 1'b0;
    check_eq("f1_instr", instr, 32'h2002_0005);
    check_eq("f1_op", 32'(op), 32'h08);
    check_eq("f1_funct", 32'(funct), 32'h05);
    check_eq("f1_pc", pc, 32'h4);
    check_eq("f1_valid", 32'(ir_valid), 32'h1);
    check_eq("f1_req_drop", 32'(imem_req), 32'h0);

    // Three wait states; fetch_start during REQ must be ignored
    fetch_start = 1'b1;
    step();
    check_eq("f2_valid_clr", 32'(ir_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("f2_wait_req", 32'(imem_req), 32'h1);
      check_eq("f2_wait_addr", imem_addr, 32'h4);
      step();
    end
    fetch_start = 1'b0;
    check_eq("f2_last_addr", imem_addr, 32'h4);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0064_1820;
    step();
    imem_ack = 1'b0;
    check_eq("f2_op", 32'(op), 32'h0);
    check_eq("f2_funct", 32'(funct), 32'h20);
    check_eq("f2_pc", pc, 32'h8);
    check_eq("f2_valid", 32'(ir_valid), 32'h1);

    // Ack outside REQ is ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check_eq("stray_ack_ir", instr, 32'h0064_1820);
    check_eq("stray_ack_pc", pc, 32'h8);

    // pc_load and fetch_start on the same edge in HOLD
    pc_load     = 1'b1;
    pc_next     = 32'h0000_0013;
    fetch_start = 1'b1;
    step();
    pc_load     = 1'b0;
    fetch_start = 1'b0;
    check_eq("ld_req", 32'(imem_req), 32'h1);
    check_eq("ld_addr", imem_addr, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 1'b0;
    check_eq("ld_pc", pc, 32'h14);
    check_eq("ld_instr", instr, 32'h1234_5678);

    // PC wrap
    pc_load = 1'b1;
    pc_next = 32'hFFFF_FFFF;
    step();
    pc_load = 1'b0;
    check_eq("wrap_load", pc, 32'hFFFF_FFFC);
    check_eq("wrap_hold_req", 32'(imem_req), 32'h0);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_5555;
    step();
    imem_ack = 1'b0;
    check_eq("wrap_pc", pc, 32'h0);

    // Asynchronous reset mid-REQ
    pc_load = 1'b1;
    pc_next = 32'h0000_0100;
    step();
    pc_load     = 1'b0;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("mid_req", 32'(imem_req), 32'h1);
    check_eq("mid_addr", imem_addr, 32'h100);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_req", 32'(imem_req), 32'h0);
    check_eq("arst_pc", pc, 32'h0);
    check_eq("arst_ir", instr, 32'h0);
    check_eq("arst_valid", 32'(ir_valid), 32'h0);
    step();
    reset = 1'b1;

    // pc_load accepted in IDLE
    pc_load = 1'b1;
    pc_next = 32'h0000_0042;
    step();
    pc_load = 1'b0;
    check_eq("idle_load_pc", pc, 32'h40);
    check_eq("idle_load_req", 32'(imem_req), 32'h0);

`ifdef FETCH_TIMEOUT_EN
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check_eq("to_req_before", 32'(imem_req), 32'h1);
    check_eq("to_err_before", 32'(fetch_err), 32'h0);
    step();
    check_eq("to_err", 32'(fetch_err), 32'h1);
    check_eq("to_req", 32'(imem_req), 32'h0);
    check_eq("to_pc", pc, 32'h40);
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check_eq("retry_addr", imem_addr, 32'h40);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    step();
    imem_ack = 1'b0;
    check_eq("retry_instr", instr, 32'h0BAD_F00D);
    check_eq("retry_pc", pc, 32'h44);
    check_eq("retry_err", 32'(fetch_err), 32'h1);
`else
    // Without the timeout, REQ waits indefinitely and fetch_err stays 0
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("noto_req", 32'(imem_req), 32'h1);
    check_eq("noto_err", 32'(fetch_err), 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    step();
    imem_ack = 1'b0;
    check_eq("noto_pc", pc, 32'h44);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
